wave_capture_ctrl: RTL

Capture controller feeding the double-buffered 512x8 waveform RAM read by the wave display. Writes 256-sample frames into the half not being displayed, starting at a rising-edge trigger on the incoming sample stream, with an auto-trigger timeout for flat or quiet inputs. Swaps the displayed half (`read_index`) only at a frame boundary, so the display never shows a half-written buffer.

---
 rtl/wave_capture_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl
// Captures 256-sample frames into the half of a double-buffered 512x8
// waveform RAM that is not being displayed. A capture starts on a rising
// crossing of TRIG_LEVEL, or on an auto-trigger after TIMEOUT quiet samples.
// The displayed half flips only on frame_start once a frame is complete.
module wave_capture_ctrl #(
    parameter logic [7:0]  TRIG_LEVEL = 8'd128,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    input  logic       frame_start,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       read_index,
    output logic [1:0] state,
    output logic       auto_trig
);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_SWAP = 2'd2,
        UNUSED    = 2'd3
    } state_t;

    state_t      state_reg,       state_next;
    logic        read_index_reg,  read_index_next;
    logic        auto_trig_reg,   auto_trig_next;
    logic [7:0]  cnt_reg,         cnt_next;
    logic [15:0] tcnt_reg,        tcnt_next;
    logic [7:0]  prev_sample_reg, prev_sample_next;
    logic        prev_ok_reg,     prev_ok_next;
    logic        wr_en_reg,       wr_en_next;
    logic [8:0]  wr_addr_reg,     wr_addr_next;
    logic [7:0]  wr_data_reg,     wr_data_next;

    logic        trigger;
    logic        timeout_hit;
    logic [15:0] tcnt_inc;

    // Rising crossing of the threshold; needs one earlier sample to compare.
    assign trigger     = sample_valid && prev_ok_reg &&
                         (prev_sample_reg < TRIG_LEVEL) && (sample >= TRIG_LEVEL);
    assign tcnt_inc    = tcnt_reg + 16'd1;
    assign timeout_hit = (TIMEOUT != 16'd0) && (tcnt_inc == TIMEOUT);

    // State and datapath registers; reset abandons any partial frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ARM;
            read_index_reg  <= 1'b0;
            auto_trig_reg   <= 1'b0;
            cnt_reg         <= 8'd0;
            tcnt_reg        <= 16'd0;
            prev_sample_reg <= 8'd0;
            prev_ok_reg     <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= 9'd0;
            wr_data_reg     <= 8'd0;
        end else begin
            state_reg       <= state_next;
            read_index_reg  <= read_index_next;
            auto_trig_reg   <= auto_trig_next;
            cnt_reg         <= cnt_next;
            tcnt_reg        <= tcnt_next;
            prev_sample_reg <= prev_sample_next;
            prev_ok_reg     <= prev_ok_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
        end
    end

    // Next-state and write-port decode; writes always target ~read_index.
    always_comb begin
        state_next       = state_reg;
        read_index_next  = read_index_reg;
        auto_trig_next   = auto_trig_reg;
        cnt_next         = cnt_reg;
        tcnt_next        = tcnt_reg;
        prev_sample_next = prev_sample_reg;
        prev_ok_next     = prev_ok_reg;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;

        // Edge history is tracked in every state so a trigger can fire on
        // the very first sample after re-arming.
        if (sample_valid) begin
            prev_sample_next = sample;
            prev_ok_next     = 1'b1;
        end

        case (state_reg)
            ARM: begin
                if (sample_valid) begin
                    tcnt_next = tcnt_inc;
                    if (trigger || timeout_hit) begin
                        wr_en_next     = 1'b1;
                        wr_addr_next   = {~read_index_reg, 8'd0};
                        wr_data_next   = sample;
                        cnt_next       = 8'd1;
                        // A real edge wins over a simultaneous timeout.
                        auto_trig_next = ~trigger;
                        state_next     = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = {~read_index_reg, cnt_reg};
                    wr_data_next = sample;
                    cnt_next     = cnt_reg + 8'd1;
                    if (cnt_reg == 8'hFF) begin
                        state_next = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    read_index_next = ~read_index_reg;
                    tcnt_next       = 16'd0;
                    state_next      = ARM;
                end
            end
            default: begin
                tcnt_next  = 16'd0;
                state_next = ARM;
            end
        endcase
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign read_index = read_index_reg;
    assign state      = state_reg;
    assign auto_trig  = auto_trig_reg;

endmodule
